// File: rtl/warp_scheduler.sv
// Round-robin warp issue stage between instruction buffer and SIMT unit.
// Optional counters enabled by defining WARP_SCHED_STATS_EN.
module warp_scheduler #(
    parameter int NUM_WARPS        = 8,
    parameter int THREADS_PER_WARP = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 instruction_in,
    input  logic                        instruction_valid,
    output logic                        instruction_ready,
    output logic [31:0]                 instruction_out,
    output logic [THREADS_PER_WARP-1:0] thread_mask,
    output logic [5:0]                  warp_id_out,
    output logic                        warp_valid,
    input  logic                        execution_ready,
    input  logic                        memory_stall,
    input  logic [5:0]                  stalled_warp_id
`ifdef WARP_SCHED_STATS_EN
    ,
    output logic [31:0]                 issue_count,
    output logic [31:0]                 stall_cycles
`endif
);

    localparam logic [THREADS_PER_WARP-1:0] FULL_MASK = '1;

    logic [NUM_WARPS-1:0]        stall_q, stall_d;
    logic [5:0]                  rr_ptr_q, rr_ptr_d;
    logic [31:0]                 instr_q, instr_d;
    logic [THREADS_PER_WARP-1:0] mask_q, mask_d;
    logic [5:0]                  wid_q, wid_d;
    logic                        wvalid_q, wvalid_d;

    logic [5:0] sel_id;
    logic       any_eligible;
    logic       issue;

    // Pick the unstalled warp closest to rr_ptr in circular order.
    always_comb begin
        int best_d;
        int d;
        best_d       = NUM_WARPS;
        d            = 0;
        sel_id       = '0;
        any_eligible = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (w >= int'(rr_ptr_q)) d = w - int'(rr_ptr_q);
            else                     d = w + NUM_WARPS - int'(rr_ptr_q);
            if (!stall_q[w] && d < best_d) begin
                best_d       = d;
                sel_id       = 6'(w);
                any_eligible = 1'b1;
            end
        end
    end

    assign instruction_ready = execution_ready && any_eligible;
    assign issue             = instruction_valid && instruction_ready;

    // Level-based stall write; ids beyond the warp count match nothing.
    always_comb begin
        stall_d = stall_q;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (6'(w) == stalled_warp_id) stall_d[w] = memory_stall;
        end
    end

    // Issue datapath: load on issue, hold otherwise; valid is a strobe.
    always_comb begin
        instr_d  = instr_q;
        mask_d   = mask_q;
        wid_d    = wid_q;
        rr_ptr_d = rr_ptr_q;
        wvalid_d = issue;
        if (issue) begin
            instr_d  = instruction_in;
            mask_d   = FULL_MASK;
            wid_d    = sel_id;
            rr_ptr_d = (int'(sel_id) == NUM_WARPS - 1) ? 6'd0 : sel_id + 6'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q  <= '0;
            rr_ptr_q <= '0;
            instr_q  <= '0;
            mask_q   <= '0;
            wid_q    <= '0;
            wvalid_q <= 1'b0;
        end else begin
            stall_q  <= stall_d;
            rr_ptr_q <= rr_ptr_d;
            instr_q  <= instr_d;
            mask_q   <= mask_d;
            wid_q    <= wid_d;
            wvalid_q <= wvalid_d;
        end
    end

    assign instruction_out = instr_q;
    assign thread_mask     = mask_q;
    assign warp_id_out     = wid_q;
    assign warp_valid      = wvalid_q;

`ifdef WARP_SCHED_STATS_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] stall_cyc_q, stall_cyc_d;

    // Count issues and cycles lost to every warp being stalled.
    always_comb begin
        issue_cnt_d = issue_cnt_q;
        stall_cyc_d = stall_cyc_q;
        if (issue) issue_cnt_d = issue_cnt_q + 32'd1;
        if (instruction_valid && execution_ready && !any_eligible)
            stall_cyc_d = stall_cyc_q + 32'd1;
    end

    // Statistics counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stall_cyc_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cyc_q <= stall_cyc_d;
        end
    end

    assign issue_count  = issue_cnt_q;
    assign stall_cycles = stall_cyc_q;
`endif

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler: issue, round robin, stalls,
// backpressure, mask and all-stalled cases.
module tb_warp_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction_in;
    logic        instruction_valid;
    logic        instruction_ready;
    logic [31:0] instruction_out;
    logic [31:0] thread_mask;
    logic [5:0]  warp_id_out;
    logic        warp_valid;
    logic        execution_ready;
    logic        memory_stall;
    logic [5:0]  stalled_warp_id;
`ifdef WARP_SCHED_STATS_EN
    logic [31:0] issue_count;
    logic [31:0] stall_cycles;
    logic [31:0] sc_prev;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    warp_scheduler #(.NUM_WARPS(8), .THREADS_PER_WARP(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instruction_in    (instruction_in),
        .instruction_valid (instruction_valid),
        .instruction_ready (instruction_ready),
        .instruction_out   (instruction_out),
        .thread_mask       (thread_mask),
        .warp_id_out       (warp_id_out),
        .warp_valid        (warp_valid),
        .execution_ready   (execution_ready),
        .memory_stall      (memory_stall),
        .stalled_warp_id   (stalled_warp_id)
`ifdef WARP_SCHED_STATS_EN
        ,
        .issue_count       (issue_count),
        .stall_cycles      (stall_cycles)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int ids_a[14] = '{1, 2, 4, 5, 6, 7, 0, 1, 2, 4, 5, 6, 7, 0};
    logic [7:0] seen;

    initial begin
        rst_n             = 1'b0;
        instruction_in    = '0;
        instruction_valid = 1'b0;
        execution_ready   = 1'b0;
        memory_stall      = 1'b0;
        stalled_warp_id   = 6'd63;
        step();
        step();
        check("rst_valid", warp_valid, 0);
        check("rst_instr", instruction_out, 0);
        check("rst_id", warp_id_out, 0);
        check("rst_mask", thread_mask, 0);
        check("rst_ready", instruction_ready, 0);
        rst_n = 1'b1;

        // Basic issue
        instruction_in    = 32'hAABBCCDD;
        instruction_valid = 1'b1;
        execution_ready   = 1'b1;
        #1;
        check("basic_ready", instruction_ready, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("basic_valid", warp_valid, 1);
            check("basic_instr", instruction_out, 32'hAABBCCDD);
            check("basic_id", warp_id_out, i);
            check("basic_mask", thread_mask, 32'hFFFFFFFF);
        end

        // Reset mid-operation drops the in-flight issue
        rst_n = 1'b0;
        step();
        check("midrst_valid", warp_valid, 0);
        check("midrst_instr", instruction_out, 0);
        check("midrst_id", warp_id_out, 0);
        rst_n = 1'b1;

        // Round robin from warp 0
        seen = '0;
        for (int i = 0; i < 16; i++) begin
            step();
            check("rr_valid", warp_valid, 1);
            check("rr_id", warp_id_out, i % 8);
            seen[warp_id_out[2:0]] = 1'b1;
        end
        check("rr_unique", seen, 8'hFF);

        // Stall warp 3; the write edge still issues warp 0
        memory_stall    = 1'b1;
        stalled_warp_id = 6'd3;
        step();
        check("stall_edge_id", warp_id_out, 0);
        stalled_warp_id = 6'd63;
        for (int i = 0; i < 14; i++) begin
            step();
            check("stall_valid", warp_valid, 1);
            check("stall_skip3", warp_id_out, ids_a[i]);
        end

        // Clear stall on warp 3; it returns in order
        memory_stall    = 1'b0;
        stalled_warp_id = 6'd3;
        step();
        check("unstall_id1", warp_id_out, 1);
        step();
        check("unstall_id2", warp_id_out, 2);
        step();
        check("unstall_id3", warp_id_out, 3);

        // Backpressure: no issue, outputs hold
        execution_ready = 1'b0;
        instruction_in  = 32'h11223344;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_ready", instruction_ready, 0);
            step();
            check("bp_valid", warp_valid, 0);
            check("bp_instr_hold", instruction_out, 32'hAABBCCDD);
            check("bp_id_hold", warp_id_out, 3);
        end
        execution_ready = 1'b1;
        step();
        check("bp_rel_valid", warp_valid, 1);
        check("bp_rel_id", warp_id_out, 4);
        check("bp_rel_instr", instruction_out, 32'h11223344);
        step();
        check("bp_rel_valid2", warp_valid, 1);
        check("bp_rel_id2", warp_id_out, 5);

        // Ready does not depend on valid
        instruction_valid = 1'b0;
        #1;
        check("novalid_ready", instruction_ready, 1);
        step();
        check("novalid_valid", warp_valid, 0);
`ifdef WARP_SCHED_STATS_EN
        check("issue_count", issue_count, 36);
`endif

        // Stall every warp in turn
        memory_stall = 1'b1;
        for (int w = 0; w < 8; w++) begin
            stalled_warp_id = 6'(w);
            step();
        end
        stalled_warp_id   = 6'd63;
        instruction_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("allst_ready", instruction_ready, 0);
`ifdef WARP_SCHED_STATS_EN
            sc_prev = stall_cycles;
`endif
            step();
            check("allst_valid", warp_valid, 0);
`ifdef WARP_SCHED_STATS_EN
            check("allst_cycles", stall_cycles - sc_prev, 1);
`endif
        end

        // Release only warp 5; it is the sole issuer
        memory_stall    = 1'b0;
        stalled_warp_id = 6'd5;
        step();
        check("rel5_none", warp_valid, 0);
        stalled_warp_id = 6'd63;
        step();
        check("rel5_valid", warp_valid, 1);
        check("rel5_id", warp_id_out, 5);
        step();
        check("rel5_id_again", warp_id_out, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
- Round-robin warp issue stage between the instruction buffer and the SIMT execution unit.
- Each cycle, picks the next eligible (non-memory-stalled) warp and issues the incoming instruction tagged with that warp's id and thread mask.
- Tracks per-warp stall status from the memory subsystem.
- Respects execution-unit backpressure.

Parameters:
- NUM_WARPS, 8, number of warp slots; legal range 1..64.
- THREADS_PER_WARP, 32, lanes per warp; width of thread_mask.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- instruction_in  input  32  instruction word from the instruction buffer.
- instruction_valid  input  1  instruction_in is valid.
- instruction_ready  output  1  scheduler can accept an instruction this cycle.
- instruction_out  output  32  issued instruction, registered.
- thread_mask  output  THREADS_PER_WARP  active-lane mask of the issued warp, registered.
- warp_id_out  output  6  id of the issued warp, registered.
- warp_valid  output  1  outputs carry an issue made in the previous cycle.
- execution_ready  input  1  execution unit can accept an issue.
- memory_stall  input  1  stall value written for stalled_warp_id.
- stalled_warp_id  input  6  warp whose stall bit is written this cycle.

Behaviour:
- Only clk and rst_n are used for timing; reset is synchronous and active-low.
- State:
  - stall_bits[NUM_WARPS]
  - mask_regs[NUM_WARPS][THREADS_PER_WARP]
  - rr_ptr (index of the next warp to consider)
  - output registers
- Reset values: all outputs 0; stall_bits all 0; mask_regs all ones; rr_ptr 0.
- eligible[w] = !stall_bits[w].
- Selection (combinational): first eligible warp searching rr_ptr, rr_ptr+1, … modulo NUM_WARPS. any_eligible is the OR of eligible[].
- instruction_ready = execution_ready && any_eligible (combinational, no dependence on instruction_valid).
- issue = instruction_valid && instruction_ready.
- On each edge with issue = 1:
  - instruction_out <= instruction_in
  - warp_id_out <= selected id
  - thread_mask <= mask_regs[selected]
  - warp_valid <= 1
  - rr_ptr <= (selected + 1) mod NUM_WARPS
- On each edge with issue = 0:
  - warp_valid <= 0
  - instruction_out, warp_id_out and thread_mask hold their values
  - rr_ptr holds
- Latency: one cycle from the issue edge to the outputs. warp_valid is a per-cycle issue strobe, not a held valid, so it is never asserted while execution_ready was low at the preceding edge.
- With continuous valid/ready and no stalls, warp_id_out cycles 0,1,…,NUM_WARPS-1,0,…; each warp is issued exactly once per NUM_WARPS cycles.
- Stall update: every edge, if stalled_warp_id < NUM_WARPS, stall_bits[stalled_warp_id] <= memory_stall; out-of-range ids are ignored. The write is level-based, so holding memory_stall = 0 on a warp id clears that warp's stall.
- Stall timing: the stall write takes effect on selection from the next cycle. An issue in the same cycle as a stall write still uses the old stall value.
- A stalled warp is skipped and rr_ptr moves past it only via normal issue; no fairness penalty is applied.
- All warps stalled: instruction_ready = 0, no issue, warp_valid = 0.
- Reset mid-operation: all state returns to reset values on that edge. Any in-flight issue is dropped.
- mask_regs are constant all-ones in the base design; no divergence handling.

Optional Feature:
- Macro WARP_SCHED_STATS_EN.
- When defined, adds outputs:
  - issue_count (32): increments on every issue edge, wraps at 2^32.
  - stall_cycles (32): increments on every edge where instruction_valid = 1 && execution_ready = 1 && !any_eligible.
  - Both counters reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Basic issue: after reset, instruction_in = 0xAABBCCDD, instruction_valid = 1, execution_ready = 1 for 5 cycles -> warp_valid = 1, instruction_out = 0xAABBCCDD, first issued warp_id_out = 0.
- Round robin: valid/ready held for 16 cycles -> warp_id_out sequence 0..7,0..7; 8 unique ids seen.
- Stall: memory_stall = 1 with stalled_warp_id = 3, held for 3 cycles -> warp 3 never appears on warp_id_out while the other 7 rotate. Then memory_stall = 0 with id 3 held -> warp 3 issued again within 8 cycles.
- Backpressure: instruction_valid = 1, execution_ready = 0 for 5 cycles -> instruction_ready = 0 and warp_valid = 0. execution_ready = 1 -> warp_valid = 1 within 1 cycle of the next edge and stays 1.
- Thread mask: any issue after reset -> thread_mask = 0xFFFFFFFF with warp_valid = 1.
- All stalled: stall warps 0..7 in turn, instruction_valid = 1 -> instruction_ready = 0 and warp_valid = 0. With WARP_SCHED_STATS_EN, stall_cycles increments by 1 per cycle.
